// File: rtl/rvfi_commit_sorter.sv
// Reorder window that collects out-of-order retirement packets from several
// writeback channels and emits them strictly in order tag sequence.
module rvfi_commit_sorter #(
  parameter int NUM_CH  = 3,
  parameter int DEPTH   = 16,
  parameter int ORDER_W = 64,
  parameter int PKT_W   = 256,
  parameter int TIMEOUT = 1024
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_CH-1:0]            in_valid,
  input  logic [NUM_CH*ORDER_W-1:0]    in_order,
  input  logic [NUM_CH*PKT_W-1:0]      in_pkt,
  input  logic                         out_ready,
  output logic                         out_valid,
  output logic [ORDER_W-1:0]           out_order,
  output logic [PKT_W-1:0]             out_pkt,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy,
  output logic                         dup_err,
  output logic                         window_err,
  output logic                         hang
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int OCC_W = $clog2(DEPTH+1);
  localparam int CNT_W = $clog2(TIMEOUT+1);
  localparam int ACC_W = $clog2(NUM_CH+1);

  logic [DEPTH-1:0]   slot_valid_r;
  logic [ORDER_W-1:0] slot_order_r [DEPTH];
  logic [PKT_W-1:0]   slot_pkt_r   [DEPTH];
  logic [ORDER_W-1:0] next_order_r;
  logic [CNT_W-1:0]   stall_cnt_r;
  logic [OCC_W-1:0]   occupancy_r;
  logic               out_valid_r;
  logic [ORDER_W-1:0] out_order_r;
  logic [PKT_W-1:0]   out_pkt_r;
  logic               dup_err_r;
  logic               window_err_r;
  logic               hang_r;

  logic [IDX_W-1:0]   head_idx_s;
  logic               drain_s;
  logic [ORDER_W-1:0] dist_s      [NUM_CH];
  logic [IDX_W-1:0]   idx_s       [NUM_CH];
  logic [NUM_CH-1:0]  in_win_s;
  logic [NUM_CH-1:0]  lower_hit_s;
  logic [NUM_CH-1:0]  accept_s;
  logic [NUM_CH-1:0]  dup_s;
  logic [NUM_CH-1:0]  win_bad_s;
  logic [ACC_W-1:0]   acc_cnt_s;
  logic [DEPTH-1:0]   slot_valid_next_s;
  logic [OCC_W-1:0]   occ_next_s;
  logic [CNT_W-1:0]   stall_next_s;

  // Per-channel window test and insert/reject classification
  always_comb begin
    head_idx_s = next_order_r[IDX_W-1:0];
    drain_s    = (~out_valid_r | out_ready) & slot_valid_r[head_idx_s];
    accept_s    = '0;
    dup_s       = '0;
    win_bad_s   = '0;
    lower_hit_s = '0;
    in_win_s    = '0;
    acc_cnt_s   = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      dist_s[i]   = in_order[i*ORDER_W +: ORDER_W] - next_order_r;
      idx_s[i]    = in_order[i*ORDER_W +: IDX_W];
      in_win_s[i] = (dist_s[i] < ORDER_W'(DEPTH));
    end
    // In-window tags map one-to-one onto slots, so a shared index means a shared tag
    for (int i = 0; i < NUM_CH; i++) begin
      for (int j = 0; j < NUM_CH; j++) begin
        lower_hit_s[i] = lower_hit_s[i] |
                         ((j < i) & in_valid[j] & in_win_s[j] & (idx_s[j] == idx_s[i]));
      end
      if (!in_valid[i]) begin
        accept_s[i] = 1'b0;
      end else if (!in_win_s[i]) begin
        win_bad_s[i] = 1'b1;
      end else if (slot_valid_r[idx_s[i]] || lower_hit_s[i]) begin
        dup_s[i] = 1'b1;
      end else begin
        accept_s[i] = 1'b1;
      end
      acc_cnt_s = acc_cnt_s + ACC_W'(accept_s[i]);
    end
  end

  // Next slot-valid vector, occupancy and stall count
  always_comb begin
    slot_valid_next_s = slot_valid_r;
    if (drain_s) begin
      slot_valid_next_s[head_idx_s] = 1'b0;
    end else begin
      slot_valid_next_s = slot_valid_r;
    end
    for (int i = 0; i < NUM_CH; i++) begin
      if (accept_s[i]) begin
        slot_valid_next_s[idx_s[i]] = 1'b1;
      end else begin
        slot_valid_next_s = slot_valid_next_s;
      end
    end
    occ_next_s = occupancy_r + OCC_W'(acc_cnt_s) - OCC_W'(drain_s);
    if (drain_s) begin
      stall_next_s = '0;
    end else if ((occupancy_r != '0) && !slot_valid_r[head_idx_s] &&
                 (stall_cnt_r != CNT_W'(TIMEOUT))) begin
      stall_next_s = stall_cnt_r + CNT_W'(1);
    end else begin
      stall_next_s = stall_cnt_r;
    end
  end

  // Control state, output register and sticky flags
  always_ff @(posedge clk) begin
    if (rst) begin
      slot_valid_r <= '0;
      next_order_r <= '0;
      stall_cnt_r  <= '0;
      occupancy_r  <= '0;
      out_valid_r  <= 1'b0;
      out_order_r  <= '0;
      out_pkt_r    <= '0;
      dup_err_r    <= 1'b0;
      window_err_r <= 1'b0;
      hang_r       <= 1'b0;
    end else begin
      slot_valid_r <= slot_valid_next_s;
      occupancy_r  <= occ_next_s;
      stall_cnt_r  <= stall_next_s;
      dup_err_r    <= dup_err_r | (|dup_s);
      window_err_r <= window_err_r | (|win_bad_s);
      hang_r       <= hang_r | (stall_next_s == CNT_W'(TIMEOUT));
      if (drain_s) begin
        out_valid_r  <= 1'b1;
        out_order_r  <= slot_order_r[head_idx_s];
        out_pkt_r    <= slot_pkt_r[head_idx_s];
        next_order_r <= next_order_r + ORDER_W'(1);
      end else if (out_ready) begin
        out_valid_r <= 1'b0;
      end
    end
  end

  // Slot payload storage; contents only matter while the valid bit is set
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_CH; i++) begin
      if (accept_s[i]) begin
        slot_order_r[idx_s[i]] <= in_order[i*ORDER_W +: ORDER_W];
        slot_pkt_r[idx_s[i]]   <= in_pkt[i*PKT_W +: PKT_W];
      end
    end
  end

  assign out_valid  = out_valid_r;
  assign out_order  = out_order_r;
  assign out_pkt    = out_pkt_r;
  assign occupancy  = occupancy_r;
  assign dup_err    = dup_err_r;
  assign window_err = window_err_r;
  assign hang       = hang_r;

endmodule

// File: tb/tb_rvfi_commit_sorter.sv
// Directed and randomized bench for rvfi_commit_sorter, compared every cycle
// against a tag-keyed reference model.
module tb_rvfi_commit_sorter;

  localparam int NUM_CH  = 3;
  localparam int DEPTH   = 16;
  localparam int ORDER_W = 64;
  localparam int PKT_W   = 32;
  localparam int TIMEOUT = 8;

  logic                        clk = 1'b0;
  logic                        rst = 1'b1;
  logic [NUM_CH-1:0]           ch_v = '0;
  logic [ORDER_W-1:0]          ch_t [NUM_CH];
  logic [PKT_W-1:0]            ch_p [NUM_CH];
  logic [NUM_CH*ORDER_W-1:0]   in_order;
  logic [NUM_CH*PKT_W-1:0]     in_pkt;
  logic                        out_ready = 1'b1;
  logic                        out_valid;
  logic [ORDER_W-1:0]          out_order;
  logic [PKT_W-1:0]            out_pkt;
  logic [$clog2(DEPTH+1)-1:0]  occupancy;
  logic                        dup_err, window_err, hang;

  int vectors = 0;
  int miscompares = 0;
  int peak = 0;
  int cnt3 = 0;
  logic [PKT_W-1:0] got7 = '0;
  logic [PKT_W-1:0] p7 = '0;

  // reference model state, keyed by order tag rather than slot
  bit [63:0]        m_next;
  logic [PKT_W-1:0] m_buf [bit [63:0]];
  bit               m_ov;
  bit [63:0]        m_oo;
  logic [PKT_W-1:0] m_op;
  int               m_stall;
  bit               m_hang, m_dup, m_win;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_pack
    assign in_order[g*ORDER_W +: ORDER_W] = ch_t[g];
    assign in_pkt[g*PKT_W +: PKT_W]       = ch_p[g];
  end

  rvfi_commit_sorter #(
    .NUM_CH(NUM_CH), .DEPTH(DEPTH), .ORDER_W(ORDER_W), .PKT_W(PKT_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(ch_v), .in_order(in_order), .in_pkt(in_pkt),
    .out_ready(out_ready), .out_valid(out_valid), .out_order(out_order), .out_pkt(out_pkt),
    .occupancy(occupancy), .dup_err(dup_err), .window_err(window_err), .hang(hang)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    bit drain;
    bit [63:0] nt [$];
    logic [PKT_W-1:0] np [$];
    bit [63:0] d;
    bit seen;
    int occ_before;
    if (rst) begin
      m_buf.delete();
      m_next = 0; m_ov = 0; m_oo = 0; m_op = '0;
      m_stall = 0; m_hang = 0; m_dup = 0; m_win = 0;
      return;
    end
    occ_before = m_buf.num();
    drain = (!m_ov || out_ready) && m_buf.exists(m_next);
    for (int c = 0; c < NUM_CH; c++) begin
      if (ch_v[c]) begin
        d = ch_t[c] - m_next;
        seen = 0;
        foreach (nt[k]) if (nt[k] == ch_t[c]) seen = 1;
        if (d >= 64'(DEPTH)) m_win = 1;
        else if (m_buf.exists(ch_t[c]) || seen) m_dup = 1;
        else begin
          nt.push_back(ch_t[c]);
          np.push_back(ch_p[c]);
        end
      end
    end
    if (drain) begin
      m_ov = 1; m_oo = m_next; m_op = m_buf[m_next];
      m_buf.delete(m_next);
      m_next = m_next + 64'd1;
      m_stall = 0;
    end else begin
      if (out_ready) m_ov = 0;
      if (occ_before > 0 && !m_buf.exists(m_next) && m_stall < TIMEOUT) m_stall++;
    end
    if (m_stall == TIMEOUT) m_hang = 1;
    foreach (nt[k]) m_buf[nt[k]] = np[k];
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    check("out_valid", out_valid, m_ov);
    check("out_order", out_order, m_oo);
    check("out_pkt", out_pkt, m_op);
    check("occupancy", occupancy, m_buf.num());
    check("dup_err", dup_err, m_dup);
    check("window_err", window_err, m_win);
    check("hang", hang, m_hang);
    if (occupancy > peak) peak = occupancy;
    if (out_valid && out_order == 64'd3 && out_ready) cnt3++;
    if (out_valid && out_order == 64'd7) got7 = out_pkt;
  endtask

  task automatic idle();
    ch_v = '0;
  endtask

  task automatic put(input int c, input logic [63:0] tag);
    ch_v[c] = 1'b1;
    ch_t[c] = tag;
    ch_p[c] = $urandom;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    peak = 0;
  endtask

  initial begin
    for (int c = 0; c < NUM_CH; c++) begin
      ch_t[c] = '0;
      ch_p[c] = '0;
    end
    rst = 1'b1;
    cycle();
    cycle();
    rst = 1'b0;
    check("rst_out_valid", out_valid, 64'd0);
    check("rst_occupancy", occupancy, 64'd0);

    // in-order stream on channel 0
    out_ready = 1'b1;
    idle(); put(0, 64'd0); cycle();
    check("lat_t1_valid", out_valid, 64'd0);
    idle(); put(0, 64'd1); cycle();
    check("lat_t2_valid", out_valid, 64'd1);
    check("lat_t2_order", out_order, 64'd0);
    for (int t = 2; t < 32; t++) begin
      idle(); put(0, 64'(t)); cycle();
    end
    idle();
    repeat (4) cycle();
    check("inorder_last", out_order, 64'd31);
    check("inorder_errs", {62'd0, dup_err, window_err}, 64'd0);

    // reverse arrival
    do_reset();
    idle(); put(2, 64'd2); cycle();
    idle(); put(1, 64'd1); cycle();
    idle(); put(0, 64'd0); cycle();
    idle();
    repeat (5) cycle();
    check("reverse_peak", 64'(peak), 64'd3);

    // simultaneous inserts and a same-cycle duplicate pair
    do_reset();
    for (int t = 0; t < 3; t++) begin
      idle(); put(0, 64'(t)); cycle();
    end
    idle(); repeat (3) cycle();
    idle(); put(0, 64'd5); put(1, 64'd3); put(2, 64'd4); cycle();
    idle(); put(0, 64'd6); cycle();
    idle(); put(0, 64'd7); put(1, 64'd7); p7 = ch_p[0]; cycle();
    idle(); repeat (5) cycle();
    check("pair_dup_err", dup_err, 64'd1);
    check("pair_keep_low", got7, p7);
    check("pair_last", out_order, 64'd7);

    // backpressure
    do_reset();
    out_ready = 1'b0;
    for (int t = 0; t < 6; t++) begin
      idle(); put(0, 64'(t)); cycle();
    end
    idle(); repeat (4) cycle();
    check("bp_order", out_order, 64'd0);
    check("bp_valid", out_valid, 64'd1);
    check("bp_occ", occupancy, 64'd5);
    out_ready = 1'b1;
    repeat (10) cycle();
    check("bp_drained_occ", occupancy, 64'd0);
    check("bp_drained_last", out_order, 64'd5);

    // window and duplicate errors
    do_reset();
    idle(); put(0, 64'd16); cycle();
    idle(); cycle();
    check("win_err", window_err, 64'd1);
    check("win_dropped", occupancy, 64'd0);
    cnt3 = 0;
    idle(); put(0, 64'd3); cycle();
    idle(); put(0, 64'd3); cycle();
    for (int t = 0; t < 3; t++) begin
      idle(); put(0, 64'(t)); cycle();
    end
    idle(); repeat (6) cycle();
    check("dup_err", dup_err, 64'd1);
    check("dup_single_out", 64'(cnt3), 64'd1);

    // hang, then reset recovery
    do_reset();
    idle(); put(0, 64'd1); cycle();
    idle(); repeat (5) cycle();
    check("hang_early", hang, 64'd0);
    repeat (5) cycle();
    check("hang_set", hang, 64'd1);
    check("hang_no_out", out_valid, 64'd0);
    do_reset();
    check("rst2_valid", out_valid, 64'd0);
    check("rst2_order", out_order, 64'd0);
    check("rst2_pkt", out_pkt, 64'd0);
    check("rst2_occ", occupancy, 64'd0);
    check("rst2_flags", {61'd0, hang, dup_err, window_err}, 64'd0);
    idle(); put(0, 64'd0); cycle();
    idle(); cycle();
    check("post_rst_valid", out_valid, 64'd1);
    check("post_rst_order", out_order, 64'd0);

    // randomized traffic around the current head
    do_reset();
    for (int n = 0; n < 400; n++) begin
      idle();
      out_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 1) == 1) put(0, m_next + 64'($urandom_range(0, 1)));
      for (int c = 1; c < NUM_CH; c++) begin
        if ($urandom_range(0, 2) == 0) put(c, m_next + 64'($urandom_range(0, DEPTH + 2)));
      end
      if ($urandom_range(0, 19) == 0) put(2, {$urandom, $urandom});
      cycle();
    end
    idle();
    out_ready = 1'b1;
    repeat (20) cycle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/rvfi_commit_sorter.md
# rvfi_commit_sorter

Parametrised retirement collector for the RVFI monitor path. It accepts up to NUM_CH out-of-order retirement packets per cycle, one per execution-unit writeback channel (ALU, LSU, BRU, ...). Each packet carries its issue order tag. The block buffers the packets in a reorder window and emits them strictly in order, one per cycle, to a single downstream port. It also flags duplicate, out-of-window and missing (hung) retirements, so the monitor sees a serial in-order stream regardless of unit count or unit latency.

## Interface
- NUM_CH, 3: number of retirement input channels (1..8).
- DEPTH, 16: reorder window size in entries; power of two, 2..256.
- ORDER_W, 64: width of order tag.
- PKT_W, 256: width of opaque payload (flattened RVFI fields excluding valid/order).
- TIMEOUT, 1024: cycles the head may stay missing before hang asserts.
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  NUM_CH  per-channel retirement strobe.
- in_order  in  NUM_CH*ORDER_W  per-channel order tag; channel i at bits [i*ORDER_W +: ORDER_W].
- in_pkt  in  NUM_CH*PKT_W  per-channel payload, packed the same way.
- out_ready  in  1  downstream accepts out packet this cycle.
- out_valid  out  1  registered; ordered packet available.
- out_order  out  ORDER_W  order tag of out packet.
- out_pkt  out  PKT_W  payload of out packet.
- occupancy  out  $clog2(DEPTH+1)  entries held in the window, excluding the out register.
- dup_err  out  1  sticky; duplicate order tag seen.
- window_err  out  1  sticky; tag outside the current window.
- hang  out  1  sticky; head missing for TIMEOUT cycles.

## Operation
- State: DEPTH slots, each holding a valid bit, order and pkt. next_order is an ORDER_W-bit register for the expected head tag. The out register holds out_valid, out_order and out_pkt. A stall counter is sized to hold TIMEOUT.
- Window test: dist = in_order - next_order, unsigned ORDER_W-bit arithmetic that wraps mod 2^ORDER_W. A tag is in window iff dist < DEPTH. The slot index is in_order[$clog2(DEPTH)-1:0].
- Insert on in_valid[i]:
  - Out of window: packet dropped, window_err set.
  - Target slot already valid: packet dropped, dup_err set, slot unchanged.
  - Two channels with the same tag in the same cycle: the lowest channel index is written; the others raise dup_err.
  - Distinct in-window tags from all channels are written in the same cycle, with no throughput limit.
- Drain: when (~out_valid | out_ready) and slot[next_order] is valid:
  - the slot moves into the out register, and the slot is cleared;
  - next_order increments by 1, wrapping at 2^ORDER_W;
  - out_valid is set to 1.
- When out_ready=1 and nothing drains, out_valid clears to 0.
- A slot written this cycle is not drainable this cycle (no bypass).
- An insert never targets the drained slot unless it is a duplicate. A duplicate insert to the slot being drained is dropped and flagged.
- occupancy = number of valid slots. Each cycle it changes by (+inserts accepted, -1 if drained).
- Hang counter:
  - Counts cycles with occupancy>0 and slot[next_order] invalid.
  - Clears to 0 whenever next_order advances.
  - Saturates at TIMEOUT; hang is set when it reaches TIMEOUT.
- Errors and hang stay set until rst. Error and hang conditions never stall draining.

## Timing
- Reset values:
  - out_valid=0, out_order=0, out_pkt=0;
  - occupancy=0, dup_err=0, window_err=0, hang=0;
  - next_order=0, all slots invalid, stall counter 0.
- rst mid-operation discards all buffered packets. The first packet accepted after reset must carry tag 0.
- Latency: a head packet presented in cycle t is written at edge t and drained at edge t+1. It appears with out_valid=1 in cycle t+2.
- Throughput: one packet out per cycle with out_ready held 1.
- Handshake: a packet transfers when out_valid & out_ready. out_order and out_pkt are held stable while out_valid & ~out_ready.
- Window full (occupancy=DEPTH) is not a special case: any new tag is either a duplicate or out of window.
- Error flags rise in the cycle after the offending input edge.

## Test plan
- In-order single channel, DEPTH=16: tags 0..31 on ch0, one per cycle, out_ready=1 -> out_order 0..31 consecutive, first out_valid 2 cycles after tag 0, no errors.
- Reverse arrival: ch2 tag 2, then ch1 tag 1, then ch0 tag 0 in three successive cycles -> out_order 0,1,2 on three consecutive cycles, occupancy peaks at 3.
- Simultaneous insert: all three channels present tags 5,3,4 after 0..2 drained -> out 3,4,5 back-to-back. A same-cycle pair tagged 7,7 -> ch with lower index kept, dup_err=1.
- Backpressure: out_ready=0 for 10 cycles with tags 0..5 delivered -> out_order stays 0 stable. occupancy=5 while stalled. Release -> 0..5 in order, nothing lost.
- Window/duplicate: next_order=0, tag 16 with DEPTH=16 -> window_err=1, dropped. Tag 3 presented twice -> dup_err=1, single out packet for 3.
- Hang and reset: TIMEOUT=8, tag 1 inserted, tag 0 never arrives -> hang=1 after 8 cycles, out_valid stays 0. Assert rst one cycle -> all outputs 0. Tag 0 then drains normally.
